// File: rtl/serial_pkg.sv
// Shared definitions for the UART blocks: line defaults, frame shape and
// the receive FSM state encoding.
package serial_pkg;

   // Line defaults, common to the transmitter and the receiver.
   localparam int unsigned DEF_CLK_FREQ = 50_000_000;
   localparam int unsigned DEF_BAUD     = 115_200;

   // 8N1 frame: eight data bits, no parity, one stop bit.
   localparam int unsigned DATA_BITS = 8;

   // Receive FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/serial_in_if.sv
// Byte stream from the UART receiver to its consumer.
//
// Handshake: 'valid' high means 'char' holds the oldest buffered byte and
// stays stable until taken. The byte is taken on a rising clock edge where
// both 'valid' and 'ready' are high. 'ready' while 'valid' is low does
// nothing. 'char' reads zero whenever 'valid' is low.
interface serial_in_if;

   logic [7:0] char;
   logic       valid;
   logic       ready;

   modport master (output char, output valid, input ready);
   modport slave  (input char, input valid, output ready);

endinterface

// File: rtl/byte_fifo.sv
// Show-ahead FIFO: the head entry is visible on rdata without a pop.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module byte_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees the slot in the same cycle, so a full FIFO can still
   // accept a push when it is being popped.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Pointer advance; natural wrap of the AW+1 bit counters.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/serial_in.sv
// UART receiver, 8N1, LSB first. Oversamples the synchronized line with a
// bit-time counter, samples mid-bit, and buffers good bytes in a FIFO.
module serial_in
   import serial_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               uart_rx,
   serial_in_if.master        rx_if,
   output logic               frame_err,
   output logic               overrun,
   output rx_state_t          state_dbg
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

   logic                 sync_1;
   logic                 rx_s;
   logic [1:0]           sync_fill;
   logic                 armed;
   rx_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;

   logic                 stop_tick;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Two-flop synchronizer, preset to the idle level.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= uart_rx;
         rx_s   <= sync_1;
      end
   end

   // The preset makes rx_s read high right after reset whatever the line
   // does; sync_fill marks when rx_s reflects the real line so that 'armed'
   // only sets once a genuine high has been seen.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && rx_s) armed <= 1'b1;
      end
   end

   // Receive FSM: start-bit check at half bit, data and stop at full bits.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (armed && !rx_s) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_HALF_END) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_BIT_END) begin
                  cnt       <= '0;
                  shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                  if (bit_idx == IDX_LAST) begin
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_BIT_END) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!rx_s) frame_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The push is decoded in the stop-sample cycle itself so the FIFO
   // captures the byte on the edge that ends that cycle.
   assign stop_tick = (state == STOP) && (cnt == CNT_BIT_END);
   assign push      = stop_tick && rx_s;
   assign pop       = rx_if.valid && rx_if.ready;

   // Overrun pulse: a good byte arrived while full and nothing left.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         overrun <= 1'b0;
      end else begin
         overrun <= push && fifo_full && !pop;
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push),
      .wdata (shift_reg),
      .pop   (pop),
      .rdata (rx_if.char),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_if.valid = !fifo_empty;
   assign state_dbg   = state;

endmodule

// File: tb/tb_serial_in.sv
// Bench for serial_in at default line settings: directed frames driven
// bit by bit, a queue of expected bytes, and a negedge monitor that pops
// and compares every byte the receiver hands over.
module tb_serial_in;
   import serial_pkg::*;

   localparam int CPB = DEF_CLK_FREQ / DEF_BAUD;   // 434
   // Falling edge driven just after edge C: sync to C+2, FSM leaves IDLE
   // at C+3, start mid-sample at C+220, data at C+220+434*k (k=1..8),
   // stop sample cycle ends at edge C+4126, valid high after it.
   localparam int LAT = 4126;

   logic      clk = 1'b0;
   logic      nrst = 1'b0;
   logic      uart_rx = 1'b1;
   logic      frame_err;
   logic      overrun;
   rx_state_t state_dbg;

   serial_in_if rx_if ();

   serial_in dut (
      .clk       (clk),
      .nrst      (nrst),
      .uart_rx   (uart_rx),
      .rx_if     (rx_if),
      .frame_err (frame_err),
      .overrun   (overrun),
      .state_dbg (state_dbg)
   );

   // clock and cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   int total = 0;
   int bad = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int valid_cycles = 0;
   int valid_rise_cyc = 0;
   int frame_start = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // monitor: pulse counting and byte comparison away from the active edge
   always @(negedge clk) begin
      if (!nrst) begin
         prev_valid = 1'b0;
      end else begin
         if (rx_if.valid) valid_cycles++;
         if (rx_if.valid && !prev_valid) valid_rise_cyc = cyc;
         prev_valid = rx_if.valid;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (frame_err || overrun) begin
            total++;
            if (frame_err && overrun) begin
               bad++;
               $display("FAIL pulse_clash: frame_err and overrun both high at cycle %0d", cyc);
            end
         end
         if (rx_if.valid && rx_if.ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_byte: got 0x%0h want no byte at cycle %0d", rx_if.char, cyc);
            end else begin
               exp_b = exp_q.pop_front();
               if (rx_if.char !== exp_b) begin
                  bad++;
                  $display("FAIL rx_byte: got 0x%0h want 0x%0h at cycle %0d", rx_if.char, exp_b, cyc);
               end
            end
         end
      end
   end

   // driver: one 8N1 frame, stop level selectable
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic accept);
      if (accept) exp_q.push_back(b);
      @(posedge clk);
      #1 uart_rx = 1'b0;
      frame_start = cyc;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 uart_rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 uart_rx = stop_val;
      repeat (CPB) @(posedge clk);
      #1 uart_rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int vc0, fe0, ov0;

   task automatic snap();
      vc0 = valid_cycles;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
   endtask

   initial begin
      rx_if.ready = 1'b0;

      // reset state
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_valid", int'(rx_if.valid), 0);
      check("rst_char", int'(rx_if.char), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_state", int'(state_dbg), int'(IDLE));
      @(posedge clk);
      #1 nrst = 1'b1;
      idle(20);

      // single byte, consumer always ready, latency check
      rx_if.ready = 1'b1;
      snap();
      send_frame(8'h41, 1'b1, 1'b1);
      idle(10);
      check("lat_0x41", valid_rise_cyc - frame_start, LAT);
      check("valid_len_0x41", valid_cycles - vc0, 1);
      check("fe_0x41", fe_cnt - fe0, 0);
      check("ov_0x41", ov_cnt - ov0, 0);
      check("q_0x41", exp_q.size(), 0);

      // 100-clock low glitch, then a real byte
      snap();
      uart_rx = 1'b0;
      idle(100);
      uart_rx = 1'b1;
      idle(600);
      check("glitch_valid", valid_cycles - vc0, 0);
      check("glitch_fe", fe_cnt - fe0, 0);
      check("glitch_state", int'(state_dbg), int'(IDLE));
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(10);
      check("q_0x5a", exp_q.size(), 0);
      check("valid_len_0x5a", valid_cycles - vc0, 1);

      // bad stop bit, then a good byte
      snap();
      send_frame(8'h33, 1'b0, 1'b0);
      idle(1000);
      check("ferr_pulse", fe_cnt - fe0, 1);
      check("ferr_valid", valid_cycles - vc0, 0);
      send_frame(8'h34, 1'b1, 1'b1);
      idle(10);
      check("q_0x34", exp_q.size(), 0);
      check("ferr_once", fe_cnt - fe0, 1);

      // overrun on the fifth byte with no consumer
      rx_if.ready = 1'b0;
      snap();
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'h02, 1'b1, 1'b1);
      send_frame(8'h03, 1'b1, 1'b1);
      send_frame(8'h04, 1'b1, 1'b1);
      send_frame(8'h05, 1'b1, 1'b0);
      idle(10);
      check("ovr_pulse", ov_cnt - ov0, 1);
      check("ovr_fe", fe_cnt - fe0, 0);
      check("ovr_head", int'(rx_if.char), 8'h01);
      rx_if.ready = 1'b1;
      idle(10);
      check("ovr_drain_q", exp_q.size(), 0);
      check("ovr_drain_valid", int'(rx_if.valid), 0);
      check("ovr_drain_char", int'(rx_if.char), 0);

      // full FIFO, pop coincides with the push of the fifth byte
      rx_if.ready = 1'b0;
      snap();
      send_frame(8'h10, 1'b1, 1'b1);
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h12, 1'b1, 1'b1);
      send_frame(8'h13, 1'b1, 1'b1);
      fork
         send_frame(8'h14, 1'b1, 1'b1);
         begin
            @(posedge clk);
            repeat (LAT - 1) @(posedge clk);
            #1 rx_if.ready = 1'b1;
            @(posedge clk);
            #1 rx_if.ready = 1'b0;
         end
      join
      idle(10);
      check("simul_ov", ov_cnt - ov0, 0);
      check("simul_head", int'(rx_if.char), 8'h11);
      check("simul_q", exp_q.size(), 4);
      rx_if.ready = 1'b1;
      idle(10);
      check("simul_drain_q", exp_q.size(), 0);
      check("simul_drain_valid", int'(rx_if.valid), 0);

      // reset during data bit 3 of 0x77; line still low at release
      snap();
      exp_b = 8'h77;
      @(posedge clk);
      #1 uart_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1 uart_rx = exp_b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 uart_rx = exp_b[3];
      idle(200);
      nrst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("midrst_valid", int'(rx_if.valid), 0);
      check("midrst_state", int'(state_dbg), int'(IDLE));
      @(posedge clk);
      #1 nrst = 1'b1;
      idle(300);
      uart_rx = 1'b1;
      idle(1000);
      check("midrst_no_byte", valid_cycles - vc0, 0);
      check("midrst_fe", fe_cnt - fe0, 0);
      check("midrst_ov", ov_cnt - ov0, 0);
      send_frame(8'h78, 1'b1, 1'b1);
      idle(10);
      check("q_0x78", exp_q.size(), 0);
      check("valid_len_0x78", valid_cycles - vc0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
